// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Block-transfer engine sitting in front of the data memory. It executes
// memcpy (Mode=0) and memset (Mode=1) requests directly on the memory port.
// While idle it passes the core's load/store port straight through; while busy
// it owns the port, returns zero read data to the core and drops core writes.
// Relies on a memory with combinational read and posedge write.
//
// Ports
//   Clk, Reset            clock, asynchronous active-low reset
//   Start, Mode           request strobe (sampled in IDLE), 0=copy / 1=fill
//   SrcAddr, DstAddr      source (copy only) and destination base addresses
//   Len                   byte count, saturated to 2**A
//   FillData              fill byte (fill only)
//   CpuAddr, CpuWrEn,
//   CpuDataIn, CpuDataOut core load/store port
//   MemAddr, MemWrEn,
//   MemDataIn, MemDataOut data memory port
//   Busy                  engine owns the memory port; core must stall
//   Done                  one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Mode,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A:0]   Len,
  input  logic [W-1:0] FillData,
  input  logic [A-1:0] CpuAddr,
  input  logic         CpuWrEn,
  input  logic [W-1:0] CpuDataIn,
  output logic [W-1:0] CpuDataOut,
  input  logic [W-1:0] MemDataOut,
  output logic [A-1:0] MemAddr,
  output logic         MemWrEn,
  output logic [W-1:0] MemDataIn,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [A:0] MAX_LEN = {1'b1, {A{1'b0}}};
  localparam logic [A:0] LEN_ONE = {{A{1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [A-1:0] src_q, dst_q;
  logic [A:0]   remaining_q;
  logic [W-1:0] hold_q, fill_q;
  logic         mode_q;
  logic [A:0]   len_sat;

  // Requests longer than the whole memory collapse to one full sweep.
  assign len_sat = (Len > MAX_LEN) ? MAX_LEN : Len;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (len_sat == '0) state_d = DONE;
          else if (Mode)     state_d = FILL;
          else               state_d = READ;
        end
      end
      READ:  state_d = WRITE;
      WRITE: state_d = (remaining_q == LEN_ONE) ? DONE : READ;
      FILL:  state_d = (remaining_q == LEN_ONE) ? DONE : FILL;
      DONE:  state_d = IDLE;  // Start is deliberately ignored here
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  // NOTE: the working registers are reset along with the state so an aborted
  // transfer leaves nothing behind; the memory itself is never cleared.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      fill_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            src_q       <= SrcAddr;
            dst_q       <= DstAddr;
            remaining_q <= len_sat;
            fill_q      <= FillData;
            mode_q      <= Mode;
          end
        end
        READ: begin
          hold_q <= MemDataOut;
          src_q  <= src_q + 1'b1;  // wraps modulo 2**A
        end
        WRITE, FILL: begin
          dst_q       <= dst_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Pass-through is the default; MemWrEn is also gated by Reset so a core
    // write can never land while the block is held in reset.
    MemAddr    = CpuAddr;
    MemWrEn    = CpuWrEn & Reset;
    MemDataIn  = CpuDataIn;
    CpuDataOut = MemDataOut;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state_q)
      READ: begin
        MemAddr    = src_q;
        MemWrEn    = 1'b0;
        CpuDataOut = '0;
        Busy       = 1'b1;
      end
      WRITE, FILL: begin
        MemAddr    = dst_q;
        MemWrEn    = 1'b1;
        MemDataIn  = mode_q ? fill_q : hold_q;
        CpuDataOut = '0;
        Busy       = 1'b1;
      end
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Bench for mem_copy_engine. Provides the 8x256 data memory (combinational
// read, posedge write) and a transfer-level model: each request is expanded
// from its byte count into the expected per-cycle port activity and into a
// model memory image. A single negedge process compares the DUT against that
// expectation every cycle; literal byte checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  localparam int W = 8;
  localparam int A = 8;

  logic         Clk, Reset;
  logic         Start, Mode;
  logic [A-1:0] SrcAddr, DstAddr;
  logic [A:0]   Len;
  logic [W-1:0] FillData;
  logic [A-1:0] CpuAddr;
  logic         CpuWrEn;
  logic [W-1:0] CpuDataIn, CpuDataOut;
  logic [W-1:0] MemDataOut;
  logic [A-1:0] MemAddr;
  logic         MemWrEn;
  logic [W-1:0] MemDataIn;
  logic         Busy, Done;

  mem_copy_engine #(.W(W), .A(A)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len), .FillData(FillData),
    .CpuAddr(CpuAddr), .CpuWrEn(CpuWrEn), .CpuDataIn(CpuDataIn),
    .CpuDataOut(CpuDataOut), .MemDataOut(MemDataOut), .MemAddr(MemAddr),
    .MemWrEn(MemWrEn), .MemDataIn(MemDataIn), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory seen by the engine.
  logic [7:0] mem [256];
  int         wr_count = 0;
  assign MemDataOut = mem[MemAddr];
  always @(posedge Clk) begin
    if (MemWrEn) begin
      mem[MemAddr] <= MemDataIn;
      wr_count     <= wr_count + 1;
    end
  end

  // Model state.
  typedef struct {
    logic       busy;
    logic       done;
    logic       wren;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] mm [256];
  logic [7:0] mm_save [256];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic w,
                              input logic [7:0] a, input logic [7:0] dt);
    exp_t e;
    e.busy = b; e.done = d; e.wren = w; e.addr = a; e.data = dt;
    return e;
  endfunction

  // Expand one request into per-cycle expectations, applying the byte moves
  // to the model memory in forward order (which defines overlap behaviour).
  task automatic build(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                       input logic [8:0] len, input logic [7:0] fill);
    int         n;
    logic [7:0] v, sa, da;
    n = (len > 9'd256) ? 256 : int'(len);
    for (int k = 0; k < n; k++) begin
      sa = 8'(int'(src) + k);
      da = 8'(int'(dst) + k);
      if (mode) begin
        mm[da] = fill;
        q.push_back(mk(1'b1, 1'b0, 1'b1, da, fill));
      end else begin
        v = mm[sa];
        q.push_back(mk(1'b1, 1'b0, 1'b0, sa, 8'h00));
        mm[da] = v;
        q.push_back(mk(1'b1, 1'b0, 1'b1, da, v));
      end
    end
    q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h00, 8'h00));  // Done cycle
    q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00));  // back in IDLE
  endtask

  // Per-cycle comparison, sampled mid-cycle.
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      check("busy", Busy, cur.busy);
      check("done", Done, cur.done);
      if (cur.busy) begin
        check("wren", MemWrEn, cur.wren);
        check("addr", MemAddr, cur.addr);
        if (cur.wren) check("wdata", MemDataIn, cur.data);
        check("cpu_rd_busy", CpuDataOut, 0);
      end else begin
        check("pt_wren", MemWrEn, CpuWrEn);
        check("pt_rd", CpuDataOut, mem[CpuAddr]);
      end
    end else if (!Reset) begin
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_wren", MemWrEn, 0);
    end else begin
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
      check("pt_addr", MemAddr, CpuAddr);
      check("pt_wren", MemWrEn, CpuWrEn);
      check("pt_wdata", MemDataIn, CpuDataIn);
      check("pt_rd", CpuDataOut, mem[CpuAddr]);
    end
  end

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge Clk); #1;
    CpuAddr = a; CpuDataIn = d; CpuWrEn = 1'b1;
    @(posedge Clk); #1;
    CpuWrEn = 1'b0;
    mm[a] = d;
  endtask

  // Presents a request so it is sampled at the next edge (edge 0); returns
  // just after edge 0 with Start dropped and the expectation queued.
  task automatic start_xfer(input logic mode, input logic [7:0] src, input logic [7:0] dst,
                            input logic [8:0] len, input logic [7:0] fill);
    @(posedge Clk); #1;
    Mode = mode; SrcAddr = src; DstAddr = dst; Len = len; FillData = fill; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    build(mode, src, dst, len, fill);
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (q.size() > 0 && c < budget) begin
      @(posedge Clk);
      c++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expected cycles left after %0d cycles", q.size(), budget);
      q.delete();
    end
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mm[i]) diffs++;
    check(name, diffs, 0);
  endtask

  initial begin
    int w0;
    Reset = 1'b0; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    FillData = '0; CpuAddr = '0; CpuDataIn = '0; CpuWrEn = 1'b1;
    #3;
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_wren_forced", MemWrEn, 0);
    CpuWrEn = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;

    // Known background pattern written through the idle pass-through.
    for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'(i) ^ 8'hC3);
    check_mem("init_image");

    // Fill 4 bytes at 0x10.
    start_xfer(1'b1, 8'h00, 8'h10, 9'd4, 8'hA5);
    wait_drain(20);
    check_mem("fill_image");
    check("fill_first", mem[8'h10], 8'hA5);
    check("fill_last", mem[8'h13], 8'hA5);
    check("fill_beyond", mem[8'h14], 8'hD7);

    // Copy 4 bytes 0x00 -> 0x80.
    cpu_write(8'h00, 8'h61); cpu_write(8'h01, 8'h62);
    cpu_write(8'h02, 8'h63); cpu_write(8'h03, 8'h64);
    start_xfer(1'b0, 8'h00, 8'h80, 9'd4, 8'h00);
    wait_drain(30);
    check_mem("copy_image");
    check("copy_first", mem[8'h80], 8'h61);
    check("copy_last", mem[8'h83], 8'h64);

    // Overlapping copy across the 0xFF -> 0x00 wrap.
    cpu_write(8'hFE, 8'h01); cpu_write(8'hFF, 8'h02); cpu_write(8'h00, 8'h03);
    start_xfer(1'b0, 8'hFE, 8'hFF, 9'd3, 8'h00);
    wait_drain(30);
    check_mem("wrap_image");
    check("wrap_ff", mem[8'hFF], 8'h01);
    check("wrap_00", mem[8'h00], 8'h01);
    check("wrap_01", mem[8'h01], 8'h01);

    // Zero-length request.
    w0 = wr_count;
    start_xfer(1'b1, 8'h00, 8'h50, 9'd0, 8'h11);
    wait_drain(10);
    check("len0_writes", wr_count - w0, 0);
    check_mem("len0_image");

    // Oversized length saturates to a full sweep.
    w0 = wr_count;
    start_xfer(1'b1, 8'h00, 8'h05, 9'h1FF, 8'h77);
    wait_drain(300);
    check("sat_writes", wr_count - w0, 256);
    check_mem("sat_image");
    check("sat_wrapped", mem[8'h04], 8'h77);

    // Stray Starts mid-copy and in the Done cycle; core write while busy.
    cpu_write(8'h30, 8'h11); cpu_write(8'h31, 8'h22); cpu_write(8'h32, 8'h33);
    start_xfer(1'b0, 8'h30, 8'h90, 9'd3, 8'h00);
    CpuAddr = 8'h40; CpuDataIn = 8'hEE; CpuWrEn = 1'b1;
    repeat (2) @(posedge Clk); #1;
    Mode = 1'b1; DstAddr = 8'h40; Len = 9'd5; FillData = 8'hEE; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk); #1;
    CpuWrEn = 1'b0; Start = 1'b1;  // held across the edge closing the Done cycle
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_drain(20);
    check_mem("stray_image");
    check("busy_core_write_dropped", mem[8'h40], 8'h77);
    check("stray_copy_last", mem[8'h92], 8'h33);

    // Asynchronous reset after 2 of 8 fill bytes.
    mm_save = mm;
    start_xfer(1'b1, 8'h00, 8'h20, 9'd8, 8'h3C);
    mm = mm_save;
    mm[8'h20] = 8'h3C;
    mm[8'h21] = 8'h3C;
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b0;
    CpuWrEn = 1'b1;
    q.delete();
    w0 = wr_count;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_wren", MemWrEn, 0);
    repeat (2) @(posedge Clk);
    #1;
    check("abort_no_writes", wr_count - w0, 0);
    CpuWrEn = 1'b0;
    @(posedge Clk); #2 Reset = 1'b1;
    check_mem("abort_image");

    // Normal operation after reset release.
    start_xfer(1'b1, 8'h00, 8'h20, 9'd2, 8'h5A);
    wait_drain(10);
    check_mem("post_reset_image");
    check("post_reset_byte", mem[8'h21], 8'h5A);

    repeat (2) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
